// File: rtl/wallace_mac_pipe.sv
// wallace_mac_pipe
//   Three-stage pipelined multiply-accumulate built around a Wallace tree.
//   One operand pair per cycle. Each sample selects signed or unsigned
//   operands. A running sum is kept with a sticky overflow flag.
//
//   Pipeline
//     S1: capture the operands and control bits of a valid sample.
//     S2: build partial products (Baugh-Wooley when signed), reduce them with
//         3:2 compressors to a sum/carry pair, and register that pair.
//     S3: carry-propagate add to form the product, accumulate, and register
//         all outputs.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand sample valid this cycle
//   in_a       multiplicand, WIDTH bits
//   in_b       multiplier, WIDTH bits
//   in_signed  1: operands are two's complement; 0: unsigned
//   acc_clr    this sample starts a new sum and clears acc_ovf
//   acc_en     this sample is added into acc (ignored when acc_clr=1)
//   out_valid  product/acc belong to the sample issued 3 cycles earlier
//   product    exact 2*WIDTH-bit product of that sample
//   acc        accumulator value after that sample, ACC_W bits
//   acc_ovf    sticky: acc has wrapped since the last acc_clr
module wallace_mac_pipe #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic               acc_clr,
  input  logic               acc_en,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] product,
  output logic [ACC_W-1:0]   acc,
  output logic               acc_ovf
);

  localparam int PW = 2*WIDTH;
  // WIDTH partial-product rows plus one row holding the Baugh-Wooley constants.
  localparam int NR = WIDTH + 1;
  // Modified Baugh-Wooley correction: +2^WIDTH and +2^(2*WIDTH-1), taken mod 2^PW.
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << WIDTH) | (PW'(1) << (PW-1));
  // Accumulator bits above the product, set when sign-extending a negative product.
  localparam logic [ACC_W-1:0] HI_MASK = ~(ACC_W'({PW{1'b1}}));

  // ---------------- S1: operand capture ----------------
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic             s1_signed_reg;
  logic             s1_clr_reg;
  logic             s1_en_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_signed_reg <= 1'b0;
      s1_clr_reg    <= 1'b0;
      s1_en_reg     <= 1'b0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_a_reg      <= in_a;
        s1_b_reg      <= in_b;
        s1_signed_reg <= in_signed;
        s1_clr_reg    <= acc_clr;
        s1_en_reg     <= acc_en;
      end
    end
  end

  // ---------------- S2: partial products + Wallace reduction ----------------
  // pp_bits[i][j] = a[j] & b[i]. In signed mode, a bit is inverted when exactly
  // one of i, j is the top index. This is the modified Baugh-Wooley form.
  logic [WIDTH-1:0][WIDTH-1:0] pp_bits;
  logic [PW-1:0]               tree_in [NR];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp_row
    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_pp_col
      localparam bit INV = (gi == WIDTH-1) ^ (gj == WIDTH-1);
      assign pp_bits[gi][gj] = (s1_a_reg[gj] & s1_b_reg[gi]) ^ (s1_signed_reg & INV);
    end
    assign tree_in[gi] = PW'(pp_bits[gi]) << gi;
  end
  assign tree_in[WIDTH] = s1_signed_reg ? BW_CONST : '0;

  // Each level compresses groups of three rows into a sum row and a carry row.
  // Leftover rows pass through unchanged. This repeats until two rows remain.
  // Carries shifted past bit PW-1 are dropped, because the product is exact mod 2^PW.
  logic [PW-1:0] csa_sum;
  logic [PW-1:0] csa_carry;

  always_comb begin : wallace_tree
    logic [PW-1:0] cur [NR+2];
    logic [PW-1:0] nxt [NR+2];
    int            n;
    int            m;
    for (int r = 0; r < NR+2; r++) begin
      cur[r] = '0;
      nxt[r] = '0;
    end
    for (int r = 0; r < NR; r++) cur[r] = tree_in[r];
    n = NR;
    m = 0;
    for (int lvl = 0; lvl < NR; lvl++) begin
      if (n > 2) begin
        for (int r = 0; r < NR+2; r++) nxt[r] = '0;
        m = 0;
        for (int g = 0; g < (NR+2)/3; g++) begin
          if (3*g+2 < n) begin
            nxt[m]   = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
            nxt[m+1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                        (cur[3*g+1] & cur[3*g+2])) << 1;
            m = m + 2;
          end else begin
            if (3*g < n) begin
              nxt[m] = cur[3*g];
              m = m + 1;
            end
            if (3*g+1 < n) begin
              nxt[m] = cur[3*g+1];
              m = m + 1;
            end
          end
        end
        cur = nxt;
        n   = m;
      end
    end
    csa_sum   = cur[0];
    csa_carry = cur[1];
  end

  logic          s2_valid_reg;
  logic [PW-1:0] s2_sum_reg;
  logic [PW-1:0] s2_carry_reg;
  logic          s2_signed_reg;
  logic          s2_clr_reg;
  logic          s2_en_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg  <= 1'b0;
      s2_sum_reg    <= '0;
      s2_carry_reg  <= '0;
      s2_signed_reg <= 1'b0;
      s2_clr_reg    <= 1'b0;
      s2_en_reg     <= 1'b0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_sum_reg    <= csa_sum;
        s2_carry_reg  <= csa_carry;
        s2_signed_reg <= s1_signed_reg;
        s2_clr_reg    <= s1_clr_reg;
        s2_en_reg     <= s1_en_reg;
      end
    end
  end

  // ---------------- S3: final add + accumulate ----------------
  logic [PW-1:0]    prod_next;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   acc_sum;
  logic             add_ovf;

  always_comb begin
    prod_next = s2_sum_reg + s2_carry_reg;
    prod_ext  = ACC_W'(prod_next);
    if (s2_signed_reg && prod_next[PW-1]) prod_ext = prod_ext | HI_MASK;
    acc_sum = {1'b0, acc} + {1'b0, prod_ext};
    // Signed mode: overflow when both addends have the same sign and the result sign differs.
    // Unsigned mode: overflow is the carry out of the top accumulator bit.
    if (s2_signed_reg)
      add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    else
      add_ovf = acc_sum[ACC_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      product   <= '0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      out_valid <= s2_valid_reg;
      // On bubble cycles product, acc and acc_ovf keep their previous values.
      if (s2_valid_reg) begin
        product <= prod_next;
        if (s2_clr_reg) begin
          acc     <= prod_ext;
          acc_ovf <= 1'b0;
        end else if (s2_en_reg) begin
          acc     <= acc_sum[ACC_W-1:0];
          acc_ovf <= acc_ovf | add_ovf;
        end
      end
    end
  end

endmodule
